// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and parity type constants shared by the UART TX and RX paths
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data register and bit index for the TX path
// Ports: CLK/RST clock and async active-low reset; load captures load_data and clears the index;
// shift_en advances the index; ser_data is the bit to drive on the line after this edge; ser_done marks the last bit on the line.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_nxt;
  // cnt indexes the bit currently on the line; ser_data looks one bit ahead so TX_OUT can stay registered
  always_comb cnt_nxt = shift_en ? cnt + 1'b1 : cnt;
  assign ser_data = data_q[cnt_nxt];
  assign ser_done = cnt == CNT_BITS'(DATA_WIDTH - 1);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      data_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt    <= '0;
    end else if (shift_en)
      cnt <= cnt_nxt;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serializes a byte LSB first as start, data, optional parity, stop at one bit per CLK
// Ports: CLK bit-rate clock; RST async active-low reset; P_DATA/PAR_EN/PAR_TYP captured on Data_Valid in IDLE;
// TX_OUT registered serial line idling high; Busy registered, high while a frame is in flight.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  uart_state_e state;
  logic        par_en_q;
  logic        par_q;
  logic        load;
  logic        shift_en;
  logic        ser_data;
  logic        ser_done;
  assign load     = state == IDLE && Data_Valid;
  assign shift_en = state == DATA && !ser_done;
  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_BITS  (CNT_BITS)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift_en (shift_en),
    .load_data(P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );
  // Parity is folded at acceptance so later P_DATA/PAR_TYP changes cannot reach the frame in flight
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else
      case (state)
        IDLE:
          if (Data_Valid) begin
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            par_en_q <= PAR_EN;
            par_q    <= ^P_DATA ^ (PAR_TYP == PAR_ODD);
          end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_data;
        end
        DATA:
          if (ser_done) begin
            state  <= par_en_q ? PARITY : STOP;
            TX_OUT <= par_en_q ? par_q : 1'b1;
          end else
            TX_OUT <= ser_data;
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx
module tb_uart_tx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  int         tests = 0;
  int         fails = 0;
  uart_tx #(.DATA_WIDTH(8), .CNT_BITS(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s tx c%0d", tag, i), TX_OUT, 1'b1);
      chk($sformatf("%s busy c%0d", tag, i), Busy, 1'b0);
      @(negedge CLK);
    end
  endtask
  // Strobe one byte, then check len line bits (exp written first-bit-first) with Busy high, then idle
  task automatic frame(input string tag, input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic [10:0] exp, input int len, input bit noise);
    P_DATA = d;
    PAR_EN = pen;
    PAR_TYP = ptyp;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s bit%0d", tag, i), TX_OUT, exp[len-1-i]);
      chk($sformatf("%s busy%0d", tag, i), Busy, 1'b1);
      if (noise && i < len - 1) begin
        Data_Valid = (i % 3 == 0);
        P_DATA = (i == 0) ? 8'hFF : 8'($urandom);
        PAR_EN = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end else
        Data_Valid = 1'b0;
      @(negedge CLK);
    end
    idle_chk({tag, " post"}, 3);
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", Busy, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    idle_chk("idle", 5);
    frame("a5_even", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b0);
    frame("a5_odd", 8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, 1'b0);
    frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 11'b0001111001, 10, 1'b0);
    frame("3c_noise", 8'h3C, 1'b0, 1'b0, 11'b0001111001, 10, 1'b1);
    P_DATA = 8'hA5;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_mid d4 tx", TX_OUT, 1'b0);
    chk("rst_mid d4 busy", Busy, 1'b1);
    RST = 1'b0;
    #1;
    chk("rst_mid tx", TX_OUT, 1'b1);
    chk("rst_mid busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    idle_chk("after_rst", 2);
    frame("01_nopar", 8'h01, 1'b0, 1'b0, 11'b0100000001, 10, 1'b0);
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    Data_Valid = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b f1 bit%0d", i), TX_OUT, i == 0 ? 1'b0 : (i == 9 ? 1'b1 : P_DATA[i-1]));
      @(negedge CLK);
    end
    chk("b2b gap tx", TX_OUT, 1'b1);
    chk("b2b gap busy", Busy, 1'b0);
    @(negedge CLK);
    chk("b2b f2 start", TX_OUT, 1'b0);
    chk("b2b f2 busy", Busy, 1'b1);
    Data_Valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
